// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter that moves I-cache and D-cache lines over one burst memory port.
// Each line moves as LINE_W/BURST_W beats; read beats are reassembled into a line buffer.
module line_mem_arbiter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;  // 1: D-cache was granted most recently
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wbuf_q, wbuf_d;
  logic [LINE_W-1:0]   rbuf_q, rbuf_d;
  logic                d_req;
  logic                grant_d;

  // Line-offset bits of the request addresses are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wbuf_d       = wbuf_q;
    rbuf_d       = rbuf_q;
    d_req        = d_read | d_write;
    grant_d      = d_req & (~i_read | ~last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          cnt_d        = '0;
          last_grant_d = grant_d;
          if (grant_d) begin
            addr_d = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (d_write) begin
              state_d = D_WR;
              wbuf_d  = d_wdata;
            end else begin
              state_d = D_RD;
            end
          end else begin
            addr_d  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state_d = I_RD;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (mem_resp) begin
          if (state_q != D_WR) begin
            rbuf_d[BURST_W*cnt_q +: BURST_W] = mem_rdata;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wbuf_q       <= wbuf_d;
      rbuf_q       <= rbuf_d;
    end
  end

  // The requester owning DONE is the one recorded in last_grant at grant time.
  assign mem_read  = (state_q == I_RD) || (state_q == D_RD);
  assign mem_write = (state_q == D_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wbuf_q[BURST_W*cnt_q +: BURST_W];
  assign i_resp    = (state_q == DONE) && !last_grant_q;
  assign d_resp    = (state_q == DONE) && last_grant_q;
  assign i_rdata   = rbuf_q;
  assign d_rdata   = rbuf_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench for line_mem_arbiter: request tasks queue expected lines, a
// negedge monitor checks grants, beats, response timing and returned data.
module tb_line_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  line_mem_arbiter #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  txn_t i_q[$];
  txn_t d_q[$];
  bit   grant_log[$];
  bit   pat_q[$];
  bit   pat_mode;
  bit   resp_rand;
  bit   idle_noise;
  int   vectors;
  int   errors;

  // Memory contents: a fixed function of line address and beat index.
  function automatic logic [63:0] mem_beat(input logic [31:0] a, input int k);
    logic [3:0] n;
    if (pat_mode) begin
      n = 4'(k + 1);
      return {16{n}};
    end
    return {a + 32'(k) * 32'h0100_0001, ~a ^ 32'(k * 7)};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h1F;
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = mem_beat(align(a), k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: counts its own beats per burst, gaps from pattern queue or random.
  int mk;
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    mk        = 0;
    forever begin
      bit r;
      @(posedge clk); #1;
      if (!rst) begin
        mk        = 0;
        mem_resp  = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end else if (mem_read || mem_write) begin
        if (pat_q.size() > 0) r = pat_q.pop_front();
        else if (resp_rand)   r = ($urandom_range(0, 99) < 60);
        else                  r = 1'b1;
        if (mk >= 4) r = 1'b0;
        mem_resp  = r;
        mem_rdata = r ? mem_beat(mem_addr, mk) : {$urandom, $urandom};
        if (r) mk++;
      end else begin
        mk        = 0;
        mem_resp  = idle_noise ? 1'($urandom) : 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor / scoreboard
  bit          m_prev_burst, m_prev_i, m_prev_d, m_prev_w;
  bit          m_last_d, m_owner_d, m_due, g_d, burst;
  int          m_beat;
  logic [31:0] m_addr;
  txn_t        m_cur;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_mem_read",  mem_read,  0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_resp",    i_resp,    0);
      chk("rst_d_resp",    d_resp,    0);
      chk("rst_i_rdata",   i_rdata,   0);
      chk("rst_d_rdata",   d_rdata,   0);
      m_prev_burst = 0; m_prev_i = 0; m_prev_d = 0; m_prev_w = 0;
      m_last_d = 1; m_owner_d = 0; m_due = 0; m_beat = 0;
    end else begin
      chk("resp_i", i_resp, m_due && !m_owner_d);
      chk("resp_d", d_resp, m_due && m_owner_d);
      if (m_due && i_resp && !m_owner_d) chk("i_rdata", i_rdata, m_cur.line);
      if (m_due && d_resp && m_owner_d && !m_cur.wr) chk("d_rdata", d_rdata, m_cur.line);
      m_due = 0;
      burst = mem_read | mem_write;
      if (burst && !m_prev_burst) begin
        chk("grant_pending", m_prev_i | m_prev_d, 1);
        g_d = m_prev_d && (!m_prev_i || !m_last_d);
        chk("grant_queue", (g_d ? d_q.size() : i_q.size()) > 0, 1);
        if (g_d && d_q.size() > 0) m_cur = d_q.pop_front();
        else if (!g_d && i_q.size() > 0) m_cur = i_q.pop_front();
        chk("grant_kind", {mem_read, mem_write}, m_cur.wr ? 2'b01 : 2'b10);
        chk("grant_addr", mem_addr, m_cur.addr);
        m_owner_d = g_d;
        m_last_d  = g_d;
        m_addr    = mem_addr;
        m_beat    = 0;
        grant_log.push_back(g_d);
      end
      if (burst) begin
        chk("addr_stable", mem_addr, m_addr);
        if (mem_resp) begin
          if (m_cur.wr) chk("wbeat", mem_wdata, m_cur.line[64*m_beat +: 64]);
          m_beat++;
          if (m_beat == 4) begin
            m_due  = 1;
            m_beat = 0;
          end
        end
      end
      m_prev_burst = burst;
      m_prev_i     = i_read;
      m_prev_d     = d_read | d_write;
      m_prev_w     = d_write;
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic i_request(input logic [31:0] a, output int lat);
    txn_t t;
    bit   done;
    t.wr   = 0;
    t.addr = align(a);
    t.line = exp_line(a);
    i_q.push_back(t);
    i_addr = a;
    i_read = 1'b1;
    lat    = 0;
    done   = 0;
    while (!done && lat < 200) begin
      cycle();
      lat++;
      if (i_resp) done = 1;
    end
    i_read = 1'b0;
    i_addr = $urandom;
    chk("i_done", done, 1);
  endtask

  task automatic d_request(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [255:0] wd, output int lat);
    txn_t t;
    bit   done;
    t.wr   = wr;
    t.addr = align(a);
    t.line = wr ? wd : exp_line(a);
    d_q.push_back(t);
    d_addr  = a;
    d_wdata = wd;
    d_read  = rd;
    d_write = wr;
    lat     = 0;
    done    = 0;
    while (!done && lat < 200) begin
      cycle();
      lat++;
      if (d_resp) done = 1;
    end
    d_read  = 1'b0;
    d_write = 1'b0;
    chk("d_done", done, 1);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive_i(input int n);
    int lat;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(1, 6)) cycle();
      i_request($urandom, lat);
    end
  endtask

  task automatic drive_d(input int n);
    int lat;
    int kind;
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(1, 6)) cycle();
      kind = $urandom_range(0, 3);
      d_request(kind != 2, kind >= 2, $urandom, rand_line(), lat);
    end
  endtask

  initial begin
    int lat, lat_i, lat_d;
    vectors = 0; errors = 0;
    pat_mode = 0; resp_rand = 0; idle_noise = 0;
    rst = 1'b0;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;

    // Reset held with random inputs
    repeat (4) begin
      cycle();
      i_read = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
      i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
    end
    cycle();
    i_read = 0; d_read = 0; d_write = 0;
    rst = 1'b1;
    repeat (10) begin
      cycle();
      chk("idle_mem_rw", {mem_read, mem_write}, 2'b00);
    end

    // Single I-cache read with recognisable beats
    pat_mode = 1;
    i_request(32'h0000_0064, lat);
    chk("t2_latency", lat, 5);
    chk("t2_addr", m_addr, 32'h0000_0060);
    chk("t2_rdata", i_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    pat_mode = 0;
    cycle();

    // D-cache writeback
    d_request(0, 1, 32'h0000_0080,
              {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
               64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA}, lat);
    chk("t3_latency", lat, 5);
    cycle();

    // Contention right after reset: I first, then D
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    grant_log.delete();
    fork
      i_request($urandom, lat_i);
      d_request(1, 0, $urandom, '0, lat_d);
    join
    chk("t4a_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("t4a_first",  grant_log[0], 0);
      chk("t4a_second", grant_log[1], 1);
    end
    chk("t4a_i_latency", lat_i, 5);
    cycle();
    i_request($urandom, lat);
    cycle();
    grant_log.delete();
    fork
      i_request($urandom, lat_i);
      d_request(1, 0, $urandom, '0, lat_d);
    join
    chk("t4b_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("t4b_first",  grant_log[0], 1);
      chk("t4b_second", grant_log[1], 0);
    end
    chk("t4b_d_latency", lat_d, 5);
    cycle();

    // Beat gaps
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    i_request($urandom, lat);
    chk("t5_latency", lat, 8);
    pat_q.delete();
    cycle();

    // Reset in the middle of a D read
    begin
      txn_t t;
      d_addr = $urandom;
      t.wr = 0; t.addr = align(d_addr); t.line = exp_line(d_addr);
      d_q.push_back(t);
      d_read = 1'b1;
      repeat (3) cycle();
      chk("t6_in_burst", mem_read, 1);
      rst = 1'b0;
      d_read = 1'b0;
      d_q.delete();
      i_q.delete();
      repeat (2) cycle();
      rst = 1'b1;
      i_request($urandom, lat);
      chk("t6_latency", lat, 5);
    end
    cycle();

    // Randomized traffic with gaps and stray idle mem_resp
    resp_rand  = 1;
    idle_noise = 1;
    fork
      drive_i(40);
      drive_d(40);
    join
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
